// File: rtl/char_plot_controller_pkg.sv
// Shared constants, state encoding and helpers for the character plot controller.
package char_plot_controller_pkg;

    localparam int unsigned SCREEN_W   = 160;
    localparam int unsigned SCREEN_H   = 120;
    localparam int unsigned CELL       = 8;
    localparam int unsigned COLS       = SCREEN_W / CELL;
    localparam int unsigned ROWS       = SCREEN_H / CELL;

    localparam logic [2:0] BLACK       = 3'b000;
    localparam logic [2:0] WHITE       = 3'b111;

    // Cycles after go with done still high before the job is abandoned.
    localparam int unsigned GO_TIMEOUT = 4;

    // Queued request layout: {char[4:0], col[4:0], row[3:0], delete}.
    localparam int unsigned REQ_W      = 15;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_GUARD,
        S_DRAW
    } plot_state_t;

    function automatic logic cell_in_range(input logic [4:0] col, input logic [3:0] row);
        return (32'(col) < COLS) && (32'(row) < ROWS);
    endfunction

endpackage

// File: rtl/char_plot_controller_req_fifo.sv
// Show-ahead synchronous FIFO holding pending character requests.
module req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 15
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (32'(count) == DEPTH);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/char_plot_controller.sv
// Queues character draw/erase requests, runs the character drawer once per
// request and turns its cell-relative pixel stream into absolute VGA writes.
module char_plot_controller
    import char_plot_controller_pkg::*;
#(
    parameter int unsigned QDEPTH      = 4,
    parameter int unsigned CELL        = 8,
    parameter int unsigned START_GUARD = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [4:0] req_char,
    input  logic [4:0] req_col,
    input  logic [3:0] req_row,
    input  logic       req_delete,
    output logic       drw_go,
    output logic [4:0] drw_char,
    output logic       drw_delete,
    input  logic [2:0] drw_x,
    input  logic [2:0] drw_y,
    input  logic [2:0] drw_colour,
    input  logic       drw_done,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy
);

    localparam int unsigned CW = $clog2(QDEPTH) + 1;

    logic [REQ_W-1:0] head;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             load;

    logic [4:0]       head_char;
    logic [4:0]       head_col;
    logic [3:0]       head_row;
    logic             head_del;

    plot_state_t      state;
    plot_state_t      state_nx;
    logic [7:0]       base_x;
    logic [6:0]       base_y;
    logic [3:0]       age;
    logic             seen_low;

    assign {head_char, head_col, head_row, head_del} = head;
    assign req_ready = !full;
    assign push      = req_valid && !full;
    assign busy      = (count != '0) || (state != S_IDLE);

    req_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (REQ_W)
    ) u_req_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .wdata  ({req_char, req_col, req_row, req_delete}),
        .pop    (pop),
        .rdata  (head),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    // Job state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, go pulse and queue pop. The head stays queued while its job
    // runs, so an in-flight job counts toward full. Done high in DRAW ends the
    // job normally once the drawer has been seen busy; otherwise it is only
    // treated as an ignored start after GO_TIMEOUT cycles.
    always_comb begin
        state_nx = state;
        drw_go   = 1'b0;
        pop      = 1'b0;
        load     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    if (cell_in_range(head_col, head_row)) begin
                        load     = 1'b1;
                        state_nx = S_START;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            S_START: begin
                drw_go   = 1'b1;
                state_nx = S_GUARD;
            end
            S_GUARD: begin
                if (32'(age) >= START_GUARD) state_nx = S_DRAW;
            end
            S_DRAW: begin
                if (drw_done && (seen_low || 32'(age) >= GO_TIMEOUT)) begin
                    pop      = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Job registers, cycles-since-go counter and the registered VGA pixel.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drw_char   <= '0;
            drw_delete <= 1'b0;
            base_x     <= '0;
            base_y     <= '0;
            age        <= '0;
            seen_low   <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else begin
            vga_plot <= 1'b0;
            if (load) begin
                drw_char   <= head_char;
                drw_delete <= head_del;
                base_x     <= 8'(32'(head_col) * CELL);
                base_y     <= 7'(32'(head_row) * CELL);
            end
            if (state == S_START) begin
                age      <= 4'd1;
                seen_low <= 1'b0;
            end else if ((state == S_GUARD || state == S_DRAW) && !seen_low && age != '1) begin
                age <= age + 1'b1;
            end
            if (state == S_DRAW && !drw_done) begin
                vga_x      <= base_x + {5'b0, drw_x};
                vga_y      <= base_y + {4'b0, drw_y};
                vga_colour <= drw_colour;
                vga_plot   <= 1'b1;
                seen_low   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_char_plot_controller.sv
// Scoreboard bench for char_plot_controller with a behavioural character drawer.
module tb_char_plot_controller;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [4:0] req_char = '0;
    logic [4:0] req_col = '0;
    logic [3:0] req_row = '0;
    logic       req_delete = 1'b0;
    logic       drw_go;
    logic [4:0] drw_char;
    logic       drw_delete;
    logic [2:0] drw_x;
    logic [2:0] drw_y;
    logic [2:0] drw_colour;
    logic       drw_done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;

    char_plot_controller #(
        .QDEPTH      (4),
        .CELL        (8),
        .START_GUARD (1)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_char   (req_char),
        .req_col    (req_col),
        .req_row    (req_row),
        .req_delete (req_delete),
        .drw_go     (drw_go),
        .drw_char   (drw_char),
        .drw_delete (drw_delete),
        .drw_x      (drw_x),
        .drw_y      (drw_y),
        .drw_colour (drw_colour),
        .drw_done   (drw_done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    typedef struct {
        logic [4:0] ch;
        logic       del;
    } job_t;

    pix_t exp_pix[$];
    job_t exp_job[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_plot = 0;
    int n_go = 0;
    int go_cyc = 0;
    int prev_go_cyc = 0;
    int plots_since_go = 0;
    int first_gap = -1;
    bit stuck_once = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Drawer model: on go, lowers done, holds pixel 0 for two setup cycles,
    // then steps one pixel per cycle in raster order and raises done after 64.
    initial begin
        int idx;
        int hold;
        bit active;
        active = 0;
        idx = 0;
        hold = 0;
        drw_done = 1'b1;
        drw_x = '0;
        drw_y = '0;
        drw_colour = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                active = 0;
                drw_done = 1'b1;
            end else if (active) begin
                if (hold > 0) begin
                    hold--;
                end else if (idx == 63) begin
                    active = 0;
                    drw_done = 1'b1;
                end else begin
                    idx++;
                    drw_x = 3'(idx % 8);
                    drw_y = 3'(idx / 8);
                end
            end else if (drw_go) begin
                if (stuck_once) begin
                    stuck_once = 0;
                end else begin
                    active = 1;
                    idx = 0;
                    hold = 2;
                    drw_done = 1'b0;
                    drw_x = '0;
                    drw_y = '0;
                    drw_colour = drw_delete ? 3'b000 : 3'b111;
                end
            end
        end
    end

    // Scoreboard monitor: pops expected pixels and jobs as the DUT emits them.
    initial begin
        pix_t e;
        job_t j;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (vga_plot) begin
                    if (plots_since_go == 0) first_gap = cyc - go_cyc;
                    plots_since_go++;
                    n_plot++;
                    n_cmp++;
                    if (exp_pix.size() == 0) begin
                        n_err++;
                        $display("FAIL plot_unexpected: got x=%0d y=%0d c=%0d, required no plot",
                                 vga_x, vga_y, vga_colour);
                    end else begin
                        e = exp_pix.pop_front();
                        if ({vga_x, vga_y, vga_colour} !== {e.x, e.y, e.c}) begin
                            n_err++;
                            $display("FAIL plot_pixel: got x=%0d y=%0d c=%0d, required x=%0d y=%0d c=%0d",
                                     vga_x, vga_y, vga_colour, e.x, e.y, e.c);
                        end
                    end
                end
                if (drw_go) begin
                    n_go++;
                    prev_go_cyc = go_cyc;
                    go_cyc = cyc;
                    plots_since_go = 0;
                    n_cmp++;
                    if (exp_job.size() == 0) begin
                        n_err++;
                        $display("FAIL go_unexpected: got go char=%0d del=%0d, required no go",
                                 drw_char, drw_delete);
                    end else begin
                        j = exp_job.pop_front();
                        if ({drw_char, drw_delete} !== {j.ch, j.del}) begin
                            n_err++;
                            $display("FAIL go_job: got char=%0d del=%0d, required char=%0d del=%0d",
                                     drw_char, drw_delete, j.ch, j.del);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Presents one request from a negedge, waits (bounded) for ready, and on
    // acceptance records what the DUT should produce. Leaves req_valid high.
    task automatic send(input logic [4:0] ch, input logic [4:0] col, input logic [3:0] row,
                        input logic del, input bit no_pix, output int stall);
        job_t j;
        pix_t p;
        stall = 0;
        req_valid = 1'b1;
        req_char = ch;
        req_col = col;
        req_row = row;
        req_delete = del;
        while (!req_ready && stall < 400) begin
            @(negedge clk);
            stall++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_ready: got req_ready=0 for %0d cycles, required acceptance", stall);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (col < 20 && row < 15) begin
            j.ch = ch;
            j.del = del;
            exp_job.push_back(j);
            if (!no_pix) begin
                for (int i = 0; i < 64; i++) begin
                    p.x = 8'(col * 8 + i % 8);
                    p.y = 7'(row * 8 + i / 8);
                    p.c = del ? 3'b000 : 3'b111;
                    exp_pix.push_back(p);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        int n;
        n = 0;
        while (busy && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_idle: got busy=%b after %0d cycles, required 0", name, busy, n);
        end
        n_cmp++;
        if (exp_pix.size() != 0 || exp_job.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: got %0d pixels and %0d jobs outstanding, required 0 and 0",
                     name, exp_pix.size(), exp_job.size());
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({vga_plot, vga_x, vga_y, vga_colour, drw_go, drw_char, drw_delete, busy}
                !== {1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 5'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_outputs: got plot=%b x=%0d y=%0d c=%0d go=%b char=%0d del=%b busy=%b, required all 0",
                     vga_plot, vga_x, vga_y, vga_colour, drw_go, drw_char, drw_delete, busy);
        end
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b, required 1", req_ready);
        end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        int p0, g0, st;
        p0 = n_plot;
        g0 = n_go;
        first_gap = -1;
        send(5'd3, 5'd2, 4'd1, 1'b0, 1'b0, st);
        req_valid = 1'b0;
        wait_idle("single", 200);
        n_cmp++;
        if (n_plot - p0 != 64) begin
            n_err++;
            $display("FAIL single_plots: got %0d, required 64", n_plot - p0);
        end
        n_cmp++;
        if (n_go - g0 != 1) begin
            n_err++;
            $display("FAIL single_go: got %0d, required 1", n_go - g0);
        end
        n_cmp++;
        if (first_gap != 3) begin
            n_err++;
            $display("FAIL single_latency: got %0d cycles go-to-first-plot, required 3", first_gap);
        end
    endtask

    task automatic test_back_to_back();
        int p0, g0, st;
        p0 = n_plot;
        g0 = n_go;
        send(5'd1, 5'd0, 4'd0, 1'b0, 1'b0, st);
        send(5'd2, 5'd4, 4'd2, 1'b1, 1'b0, st);
        send(5'd5, 5'd10, 4'd7, 1'b0, 1'b0, st);
        send(5'd6, 5'd19, 4'd0, 1'b0, 1'b0, st);
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_full: got req_ready=%b after 4 accepts, required 0", req_ready);
        end
        send(5'd8, 5'd0, 4'd14, 1'b1, 1'b0, st);
        req_valid = 1'b0;
        n_cmp++;
        if (st < 1) begin
            n_err++;
            $display("FAIL b2b_hold: got stall=%0d for 5th request, required >0", st);
        end
        wait_idle("b2b", 2000);
        n_cmp++;
        if (n_plot - p0 != 320 || n_go - g0 != 5) begin
            n_err++;
            $display("FAIL b2b_counts: got plots=%0d gos=%0d, required 320 and 5", n_plot - p0, n_go - g0);
        end
    endtask

    task automatic test_corner();
        int p0, st;
        p0 = n_plot;
        send(5'd7, 5'd19, 4'd14, 1'b1, 1'b0, st);
        req_valid = 1'b0;
        wait_idle("corner", 200);
        n_cmp++;
        if (n_plot - p0 != 64) begin
            n_err++;
            $display("FAIL corner_plots: got %0d, required 64", n_plot - p0);
        end
    endtask

    task automatic test_invalid();
        int p0, g0, st;
        p0 = n_plot;
        g0 = n_go;
        send(5'd9, 5'd25, 4'd3, 1'b0, 1'b0, st);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL invalid_col_busy: got busy=%b 2 cycles after accept, required 0", busy);
        end
        send(5'd10, 5'd0, 4'd15, 1'b1, 1'b0, st);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL invalid_row_busy: got busy=%b 2 cycles after accept, required 0", busy);
        end
        repeat (10) @(negedge clk);
        n_cmp++;
        if (n_go != g0 || n_plot != p0) begin
            n_err++;
            $display("FAIL invalid_activity: got gos=%0d plots=%0d, required 0 and 0", n_go - g0, n_plot - p0);
        end
    endtask

    task automatic test_timeout();
        int p0, g0, st;
        p0 = n_plot;
        g0 = n_go;
        stuck_once = 1;
        send(5'd11, 5'd1, 4'd1, 1'b0, 1'b1, st);
        send(5'd12, 5'd3, 4'd3, 1'b0, 1'b0, st);
        req_valid = 1'b0;
        wait_idle("timeout", 500);
        n_cmp++;
        if (n_go - g0 != 2 || n_plot - p0 != 64) begin
            n_err++;
            $display("FAIL timeout_counts: got gos=%0d plots=%0d, required 2 and 64", n_go - g0, n_plot - p0);
        end
        n_cmp++;
        if (go_cyc - prev_go_cyc != 6) begin
            n_err++;
            $display("FAIL timeout_gap: got %0d cycles between go pulses, required 6", go_cyc - prev_go_cyc);
        end
    endtask

    task automatic test_reset_mid();
        int p0, g0, st, n;
        p0 = n_plot;
        send(5'd20, 5'd5, 4'd5, 1'b0, 1'b0, st);
        req_valid = 1'b0;
        n = 0;
        while (n_plot - p0 < 30 && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        n_cmp++;
        if (n_plot - p0 != 30) begin
            n_err++;
            $display("FAIL midreset_reach: got %0d plots, required 30", n_plot - p0);
        end
        resetn = 1'b0;
        #1;
        n_cmp++;
        if ({vga_plot, busy, req_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL midreset_outputs: got plot=%b busy=%b ready=%b, required 0 0 1",
                     vga_plot, busy, req_ready);
        end
        exp_pix.delete();
        exp_job.delete();
        g0 = n_go;
        p0 = n_plot;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (n_go != g0 || n_plot != p0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_quiet: got gos=%0d plots=%0d busy=%b, required 0 0 0",
                     n_go - g0, n_plot - p0, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_corner();
        test_invalid();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/char_plot_controller.md
Name: char_plot_controller

Overview:
- Initiator and consumer for the character pixel-stream interface (go / draw_x / draw_y / colour / done).
- Accepts character draw or erase requests through a valid/ready handshake and buffers them in a 4-deep queue.
- Starts the external character drawer once per request and converts its cell-relative pixel stream into absolute VGA adapter writes (x, y, colour, plot).
- Sits between the game/word logic and the 160x120 VGA adapter.

Parameters:
- QDEPTH, 4, request queue depth; power of two, minimum 2.
- CELL, 8, character cell size in pixels; fixed to match the 3-bit relative coordinates.
- START_GUARD, 1, idle cycles after go before done is sampled.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  queue not full.
- req_char  in  5  character_id to draw.
- req_col  in  5  cell column, 0..19.
- req_row  in  4  cell row, 0..14.
- req_delete  in  1  1 = erase the cell (black), 0 = draw.
- drw_go  out  1  start pulse to the drawer.
- drw_char  out  5  character_id to the drawer; held stable for the whole job.
- drw_delete  out  1  delete flag to the drawer; held stable for the whole job.
- drw_x  in  3  relative pixel x.
- drw_y  in  3  relative pixel y.
- drw_colour  in  3  pixel colour.
- drw_done  in  1  drawer finished; high when idle.
- vga_x  out  8  absolute pixel x.
- vga_y  out  7  absolute pixel y.
- vga_colour  out  3  pixel colour.
- vga_plot  out  1  write enable to the VGA adapter.
- busy  out  1  queue non-empty or job in flight.

Behaviour:
- Reset (resetn low, async): queue empty; FSM in IDLE; drw_go=0; vga_plot=0; vga_x=0; vga_y=0; vga_colour=0; drw_char=0; drw_delete=0; busy=0; req_ready=1.
- Enqueue: a request is accepted on any clock edge where req_valid and req_ready are both high.
  - req_ready = !full, combinational from the queue count.
  - A request with req_col>19 or req_row>14 is accepted and then discarded at dequeue: no go pulse, no plots.
  - Simultaneous enqueue and dequeue when full is not allowed; ready is already low when full.
- FSM states:
  - IDLE: if the queue is non-empty, load the head into job registers (char, delete, base_x=col*8, base_y=row*8) and go to START.
  - START: drw_go=1 for exactly one cycle, then go to GUARD.
  - GUARD: wait START_GUARD cycles, then go to DRAW.
  - DRAW: each cycle drw_done=0, register one pixel to the VGA outputs:
    - vga_x <= base_x + drw_x
    - vga_y <= base_y + drw_y
    - vga_colour <= drw_colour
    - vga_plot <= 1
  - DRAW exit: on the first cycle drw_done=1, set vga_plot <= 0, pop the queue head, and go to IDLE.
- Latency: VGA outputs lag the drawer pixel by one cycle.
  - First vga_plot appears 3 cycles after leaving IDLE (START, GUARD, DRAW register).
  - A full 8x8 cell produces exactly 64 plot cycles.
- Arithmetic: base_x is 8 bits (max 152) and base_y is 7 bits (max 112). Sums are at most 159/119, so no wrap can occur with legal inputs.
- Timeout: if drw_done is still high 4 cycles after go, the drawer ignored the start. Abort the job: pop the request, return to IDLE, no plots.
- Ordering: requests complete in FIFO order; one job is in flight at a time.
- busy = (count != 0) | (state != IDLE).
- Reset asserted mid-job: all state clears immediately; queued requests are lost; vga_plot falls asynchronously.

Decomposition:
- Shared package holds:
  - SCREEN_W=160, SCREEN_H=120, CELL=8, COLS=20, ROWS=15.
  - Colour constants BLACK=3'b000, WHITE=3'b111.
  - FSM state encoding.
- One natural sub-module: req_fifo, a parameterised synchronous FIFO with count, full and empty, storing 15-bit requests {char, col, row, delete}.

Test Plan:
- Reset, then one request (char=3, col=2, row=1, delete=0) with a behavioural 64-pixel drawer model -> one drw_go pulse; 64 plots spanning x 16..23, y 8..15; colour 3'b111; busy returns to 0.
- Five back-to-back requests while the drawer is busy -> req_ready drops after the 4th accept; the 5th is held until a pop; outputs appear in submission order.
- Request col=19, row=14, delete=1 -> plots cover x 152..159, y 112..119, colour 3'b000.
- Request col=25 -> accepted, no drw_go, no plots, busy clears within 2 cycles.
- Drawer model that never lowers done -> abort 4 cycles after go, zero plots, next queued request proceeds.
- Assert resetn low during the 30th pixel -> vga_plot=0 immediately, busy=0, req_ready=1, no further drw_go.
